// File: rtl/fifo_uart_pkg.sv
// Shared types and frame constants for the FIFO-to-UART drain stage.
// Frame length follows FIFO_UART_TX_PARITY_EN (8N1 by default, 8E1 when defined).
package fifo_uart_pkg;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int BITS_PER_FRAME = 11;
`else
    localparam int BITS_PER_FRAME = 10;
`endif
    localparam int FRAMES_PER_WORD = DATA_W / BYTE_W;
    localparam int BITS_PER_WORD   = BITS_PER_FRAME * FRAMES_PER_WORD;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter, 0..CLKS_PER_BIT-1, bit_done on the last count.
// Latency: bit_done is combinational from the counter; first tick CLKS_PER_BIT cycles after restart drops.
// Backpressure: none; restart holds the counter at zero.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign bit_done = (cnt == LAST) && !restart;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 16-bit FIFO words and sends each as two UART frames, low byte first (FIFO_UART_TX_PARITY_EN adds an even parity bit).
// Latency: start bit 2 clk after IDLE sees fifo_empty=0; 20 (22 with parity) bit-times per word, 3 idle clk between words.
// Backpressure: fifo_re only from IDLE, one read outstanding at most; a missing fifo_valid flags err after WAIT_LIMIT clk.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int WAIT_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic              fifo_re,
    output logic              txd,
    output logic              busy,
    output logic              err,
    output logic [15:0]       words_sent
);

    localparam int              WC_W      = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_LIMIT - 1);

    tx_state_t         state, state_n;
    logic [DATA_W-1:0] word_q, word_n;
    logic              byte_idx, byte_n;
    logic [2:0]        bit_idx, bit_n, bit_nxt;
    logic [WC_W-1:0]   wait_cnt, wait_n;
    logic              txd_n, re_n, err_n;
    logic [15:0]       sent_n;
    logic [BYTE_W-1:0] cur_byte;
    logic              restart, bit_done;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bit_done(bit_done)
    );

    // The baud counter only runs while a frame is on the line.
    assign restart  = (state == IDLE) || (state == WAIT);
    assign cur_byte = byte_idx ? word_q[DATA_W-1:BYTE_W] : word_q[BYTE_W-1:0];
    assign bit_nxt  = bit_idx + 3'd1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            word_q     <= '0;
            byte_idx   <= 1'b0;
            bit_idx    <= '0;
            wait_cnt   <= '0;
            txd        <= 1'b1;
            fifo_re    <= 1'b0;
            err        <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_n;
            word_q     <= word_n;
            byte_idx   <= byte_n;
            bit_idx    <= bit_n;
            wait_cnt   <= wait_n;
            txd        <= txd_n;
            fifo_re    <= re_n;
            err        <= err_n;
            words_sent <= sent_n;
        end
    end

    // Next values are computed for the registered outputs, so txd changes on the same edge as the state.
    always_comb begin
        state_n = state;
        word_n  = word_q;
        byte_n  = byte_idx;
        bit_n   = bit_idx;
        wait_n  = wait_cnt;
        txd_n   = txd;
        re_n    = 1'b0;
        err_n   = err;
        sent_n  = words_sent;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    re_n    = 1'b1;
                    wait_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (fifo_valid) begin
                    word_n  = fifo_dout;
                    byte_n  = 1'b0;
                    txd_n   = 1'b0;
                    state_n = START;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_n   = '0;
                    txd_n   = cur_byte[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        txd_n   = ^cur_byte;
                        state_n = PARITY;
`else
                        txd_n   = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_nxt;
                        txd_n = cur_byte[bit_nxt];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    txd_n   = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (!byte_idx) begin
                        byte_n  = 1'b1;
                        txd_n   = 1'b0;
                        state_n = START;
                    end else begin
                        sent_n  = words_sent + 16'd1;
                        txd_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a 1-cycle registered-read FIFO model and CLKS_PER_BIT=4.
// FIFO_UART_TX_PARITY_EN selects 11-bit frames in the line checker.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int WLIM = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk, rst;
    logic        fifo_empty, fifo_valid, fifo_re;
    logic [15:0] fifo_dout;
    logic        txd, busy, err;
    logic [15:0] words_sent;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int re_cnt = 0;
    int re_cyc = 0;
    int starve_left = 0;
    int first_low_cyc = 0;

    logic [15:0] q[$];
    bit          pend;
    logic [15:0] pend_dat;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WAIT_LIMIT  (WLIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_valid(fifo_valid),
        .fifo_re   (fifo_re),
        .txd       (txd),
        .busy      (busy),
        .err       (err),
        .words_sent(words_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // FIFO: re seen in one cycle gives dout/valid in the next; starve_left fakes a non-empty flag with no data.
    initial begin
        pend       = 1'b0;
        pend_dat   = '0;
        fifo_empty = 1'b1;
        fifo_valid = 1'b0;
        fifo_dout  = '0;
        forever begin
            @(negedge clk);
            fifo_valid = pend;
            if (pend) fifo_dout = pend_dat;
            pend = 1'b0;
            if (fifo_re === 1'b1) begin
                re_cnt++;
                re_cyc = cyc;
                if (starve_left > 0) begin
                    starve_left--;
                end else if (q.size() > 0) begin
                    pend_dat = q.pop_front();
                    pend     = 1'b1;
                end
            end
            fifo_empty = (starve_left == 0) && (q.size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Waits for a start bit, then checks every sample of every bit of one frame.
    task automatic check_frame(input string tag, input logic [7:0] b, input logic p, output int gap);
        logic [CPB-1:0] v;
        logic           e;
        bit             found;
        gap   = 0;
        found = 1'b0;
        v     = '0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
            else gap++;
        end
        chk({tag, "_start"}, 32'(found), 32'd1);
        if (found) begin
            first_low_cyc = cyc;
            for (int k = 0; k < NBITS; k++) begin
                for (int j = 0; j < CPB; j++) begin
                    if (k != 0 || j != 0) @(negedge clk);
                    v[j] = txd;
                end
                if (k == 0) e = 1'b0;
                else if (k <= 8) e = b[k-1];
                else if (k == NBITS - 1) e = 1'b1;
                else e = p;
                chk($sformatf("%s_bit%0d", tag, k), 32'(v), 32'({CPB{e}}));
            end
        end
    endtask

    initial begin
        int   gap;
        int   t0;
        int   n;
        bit   found;
        logic txd_and;

        // Reset state and quiet idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_re", 32'(fifo_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sent", 32'(words_sent), 32'd0);
        rst    = 1'b0;
        re_cnt = 0;
        repeat (20) @(negedge clk);
        chk("idle_no_re", 32'(re_cnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_txd", 32'(txd), 32'd1);

        // Single word 0x1234
        re_cnt = 0;
        q.push_back(16'h1234);
        check_frame("w1234_lo", 8'h34, 1'b1, gap);
        chk("lat_re_to_start", 32'(first_low_cyc - re_cyc), 32'd2);
        check_frame("w1234_hi", 8'h12, 1'b0, gap);
        chk("w1234_gap", 32'(gap), 32'd0);
        @(negedge clk);
        chk("w1234_sent", 32'(words_sent), 32'd1);
        chk("w1234_re", 32'(re_cnt), 32'd1);
        chk("w1234_busy", 32'(busy), 32'd0);

        // Back-to-back 0x0001, 0x00FF
        re_cnt = 0;
        q.push_back(16'h0001);
        q.push_back(16'h00FF);
        check_frame("w0001_lo", 8'h01, 1'b1, gap);
        t0 = first_low_cyc;
        check_frame("w0001_hi", 8'h00, 1'b0, gap);
        check_frame("w00ff_lo", 8'hFF, 1'b0, gap);
        chk("b2b_gap", 32'(gap), 32'd3);
        check_frame("w00ff_hi", 8'h00, 1'b0, gap);
        @(negedge clk);
        chk("b2b_sent", 32'(words_sent), 32'd3);
        chk("b2b_time", 32'(cyc - t0), 32'(4 * NBITS * CPB + 3));
        chk("b2b_re", 32'(re_cnt), 32'd2);

        // Underflow: non-empty flag but no read data
        re_cnt      = 0;
        starve_left = 1;
        found       = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_re === 1'b1) found = 1'b1;
        end
        chk("uf_re", 32'(found), 32'd1);
        n       = 0;
        txd_and = txd;
        while (err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            txd_and = txd_and & txd;
        end
        chk("uf_wait_cycles", 32'(n), 32'(WLIM));
        chk("uf_busy", 32'(busy), 32'd0);
        repeat (20) begin
            @(negedge clk);
            txd_and = txd_and & txd;
        end
        chk("uf_err_sticky", 32'(err), 32'd1);
        chk("uf_txd_high", 32'(txd_and), 32'd1);
        chk("uf_re_once", 32'(re_cnt), 32'd1);
        chk("uf_sent", 32'(words_sent), 32'd3);

        // Reset during data bit 3 of byte 0 (0xA5: bit3 = 0)
        q.push_back(16'h00A5);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
        end
        chk("mr_start", 32'(found), 32'd1);
        repeat (4 * CPB) @(negedge clk);
        chk("mr_bit3", 32'(txd), 32'd0);
        chk("mr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_txd", 32'(txd), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_sent", 32'(words_sent), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        rst    = 1'b0;
        re_cnt = 0;
        q.push_back(16'hC35A);
        check_frame("wc35a_lo", 8'h5A, 1'b0, gap);
        check_frame("wc35a_hi", 8'hC3, 1'b0, gap);
        @(negedge clk);
        chk("wc35a_sent", 32'(words_sent), 32'd1);
        chk("wc35a_re", 32'(re_cnt), 32'd1);

        // Word 0x0703: parity bits 0 then 1 when enabled
        q.push_back(16'h0703);
        check_frame("w0703_lo", 8'h03, 1'b0, gap);
        check_frame("w0703_hi", 8'h07, 1'b1, gap);
        chk("w0703_gap", 32'(gap), 32'd0);
        @(negedge clk);
        chk("w0703_sent", 32'(words_sent), 32'd2);
        chk("w0703_err", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 16-bit `fifo`. It pops one word at a time through the FIFO's registered-read handshake (re, then dout/valid one cycle later). It transmits each word on a UART line as two 8N1 frames, low byte first. It is the drain stage between the FIFO and the board TX pin.

Parameters:
- CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200). Legal range is 2 to 65535.
- WAIT_LIMIT, default 4: maximum cycles spent in WAIT for fifo_valid before an underflow error is declared.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  16  FIFO read data
- fifo_valid  in  1  FIFO read-data-valid, asserted one cycle after a sampled re
- fifo_re  out  1  FIFO read enable; registered single-cycle pulse
- txd  out  1  UART serial output; idle high
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky underflow error; cleared only by rst
- words_sent  out  16  count of fully transmitted words; wraps at 0xFFFF to 0

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: txd=1, fifo_re=0, busy=0, err=0, words_sent=0, state=IDLE, byte index=0, bit and baud counters=0.
- All outputs are registered. busy is decoded from the state register.
- States: IDLE, WAIT, START, DATA, STOP. PARITY is present only with the optional feature.
- IDLE:
  - If fifo_empty=0: fifo_re<=1 for exactly one cycle, then go to WAIT.
  - Otherwise stay in IDLE with txd=1.
- WAIT:
  - fifo_re<=0.
  - On fifo_valid=1: latch fifo_dout into a 16-bit shift word, byte index<=0, go to START.
  - If WAIT_LIMIT cycles pass with no valid: err<=1, return to IDLE. No frame is sent.
  - fifo_valid seen in any state other than WAIT is ignored.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Byte 0 = word[7:0]; byte 1 = word[15:8].
- STOP: txd=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - If byte index is 0: byte index<=1, go to START. There is no idle gap between the two frames.
  - If byte index is 1: words_sent<=words_sent+1, go to IDLE.
- Latency, idle to line:
  - An edge where IDLE sees fifo_empty=0 is called E.
  - The first start bit drives txd low from E+2, against a FIFO with 1-cycle read latency.
  - Word duration is 20*CLKS_PER_BIT cycles.
- Back-to-back words: the gap between the last stop bit and the next start bit is exactly 3 clk cycles of txd=1 (IDLE, WAIT, valid capture).
- fifo_re is never asserted outside IDLE. At most one read is outstanding at a time, so the block can never cause FIFO underflow while fifo_empty is honoured.
- Reset mid-frame:
  - txd returns to 1 on the next edge. All state is cleared.
  - A word already popped is discarded.
  - err and words_sent are cleared.
- Baud counter: an internal counter counts 0 to CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.

Optional Feature:
FIFO_UART_TX_PARITY_EN
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even parity of the current byte (XOR of its 8 bits) for CLKS_PER_BIT cycles.
  - Word duration becomes 22*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, and frames are 8N1.

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum (IDLE, WAIT, START, DATA, STOP, PARITY);
  - DATA_W=16 and BYTE_W=8;
  - the frame-length constants.
- One natural sub-module is uart_bit_timer. It holds the baud counter and emits a one-cycle bit_done tick, with a restart input.

Test Plan:
- Reset state: hold rst=1 for 2 cycles, fifo_empty=1 -> txd=1, fifo_re=0, busy=0, err=0, words_sent=0, and no re over 20 cycles.
- Single word, CLKS_PER_BIT=4:
  - Stimulus: push 0x1234.
  - Line: txd shows start, then 0x34 LSB-first (0,0,1,0,1,1,0,0), stop, start, then 0x12 (0,1,0,0,1,0,0,0), stop.
  - Counts: words_sent=1 and exactly one fifo_re pulse.
- Back-to-back:
  - Stimulus: FIFO pre-filled with 0x0001 and 0x00FF.
  - Line: exactly 3 idle-high cycles between the frames.
  - Counts: two re pulses, and words_sent=2 after 2*80+3+2 cycles.
- Underflow: drive fifo_empty=0 with fifo_valid held 0 -> after WAIT_LIMIT cycles err=1, txd stays 1, busy returns 0, and err stays 1 until rst.
- Reset mid-operation: assert rst during DATA bit 3 of byte 0 -> txd=1 on the next edge, busy=0, words_sent=0, and normal transfer resumes on the next word.
- Parity, with FIFO_UART_TX_PARITY_EN defined:
  - Stimulus: word 0x0703.
  - Parity bits: byte 0x03 gets parity bit 0 and byte 0x07 gets parity bit 1.
  - Frame: 11 bit-times per byte.
